// File: rtl/clk_divider_multi.sv
// N-channel programmable clock divider: each channel produces a 50% square wave and a
// one-cycle tick from the 50 MHz board clock, with a shadowed, glitch-free divide update.
module clk_divider_multi #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 99999,
  parameter int          CH_W        = 2
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  // Handshake: div_wr is a single-cycle strobe with no ready; a write is accepted on
  // the edge it is sampled, provided div_ch names an existing channel.

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  div_act [NUM_CH];
  logic [CNT_W-1:0]  div_shd [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] commit;
  logic [NUM_CH-1:0] wr_hit;

  always_comb begin
    wrap   = '0;
    commit = '0;
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]   = en[i] && (cnt[i] == div_act[i]);
      // A pending value lands at a wrap, or immediately while the channel is idle.
      commit[i] = pend[i] && (wrap[i] || !en[i]);
      wr_hit[i] = div_wr && (div_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    always_ff @(posedge clk_50mhz) begin
      if (rst) begin
        cnt[g]     <= '0;
        div_act[g] <= DIV_RST;
        div_shd[g] <= DIV_RST;
        pend[g]    <= 1'b0;
        clk_out[g] <= 1'b0;
        tick[g]    <= 1'b0;
      end else begin
        if (en[g]) begin
          if (wrap[g]) begin
            cnt[g]     <= '0;
            clk_out[g] <= ~clk_out[g];
            tick[g]    <= 1'b1;
          end else begin
            cnt[g]  <= cnt[g] + 1'b1;
            tick[g] <= 1'b0;
          end
        end else begin
          tick[g] <= 1'b0;
          if (pend[g]) cnt[g] <= '0;
        end

        if (commit[g]) div_act[g] <= div_shd[g];

        // The commit uses the old shadow; a coincident write re-arms pend.
        if (wr_hit[g]) begin
          div_shd[g] <= div_val;
          pend[g]    <= 1'b1;
        end else if (commit[g]) begin
          pend[g] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: directed scenarios and random traffic compared every cycle
// against a countdown-based behavioural model of each channel.
module tb_clk_divider_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DEF = 3;
  localparam int CHW = 3;

  logic           clk_50mhz = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           div_wr = 1'b0;
  logic [CHW-1:0] div_ch = '0;
  logic [CW-1:0]  div_val = '0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;

  clk_divider_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF), .CH_W(CHW)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .en(en), .div_wr(div_wr), .div_ch(div_ch),
    .div_val(div_val), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: cycles left before the next toggle, plus active/shadow divide values.
  int m_left [NCH];
  int m_act  [NCH];
  int m_shd  [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];

  logic [NCH-1:0] exp_clk, exp_tick, exp_pend;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_left[c] = DEF; m_act[c] = DEF; m_shd[c] = DEF;
        m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (en[c]) begin
          if (m_left[c] == 0) begin
            if (m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
            m_clk[c]  = ~m_clk[c];
            m_tick[c] = 1;
            m_left[c] = m_act[c];
          end else begin
            m_left[c]--;
            m_tick[c] = 0;
          end
        end else begin
          m_tick[c] = 0;
          if (m_pend[c]) begin
            m_act[c] = m_shd[c]; m_pend[c] = 0; m_left[c] = m_act[c];
          end
        end
        if (div_wr && (int'(div_ch) == c)) begin
          m_shd[c]  = int'(div_val);
          m_pend[c] = 1;
        end
      end
    end
  endtask

  always @(posedge clk_50mhz) begin
    model_step();
    #1;
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        exp_clk[c] = m_clk[c]; exp_tick[c] = m_tick[c]; exp_pend[c] = m_pend[c];
      end
      chk("clk_out", 32'(clk_out), 32'(exp_clk));
      chk("tick", 32'(tick), 32'(exp_tick));
      chk("pend", 32'(pend), 32'(exp_pend));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic write(input int ch, input int val);
    div_wr = 1'b1; div_ch = CHW'(ch); div_val = CW'(val);
    @(negedge clk_50mhz);
    div_wr = 1'b0;
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_clk", 32'(clk_out), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_pend", 32'(pend), 32'h0);

    // 1: default divide 3 toggles at cycles 4, 8 after enable.
    en = 4'hF;
    repeat (3) @(posedge clk_50mhz);
    #2 chk("t1_c3_clk", 32'(clk_out), 32'h0);
    @(posedge clk_50mhz);
    #2 chk("t1_c4_clk", 32'(clk_out), 32'hF);
    chk("t1_c4_tick", 32'(tick), 32'hF);
    @(posedge clk_50mhz);
    #2 chk("t1_c5_tick", 32'(tick), 32'h0);
    repeat (3) @(posedge clk_50mhz);
    #2 chk("t1_c8_clk", 32'(clk_out), 32'h0);
    chk("t1_c8_tick", 32'(tick), 32'hF);
    @(negedge clk_50mhz);

    // 2: ch1 to divide 1, mid-period.
    cycles(1);
    write(1, 1);
    chk("t2_pend1", 32'(pend[1]), 32'h1);
    cycles(12);

    // 3: ch2 to divide 0, then tick[2] held high.
    write(2, 0);
    cycles(6);
    for (int k = 0; k < 4; k++) begin
      chk("t3_tick2_high", 32'(tick[2]), 32'h1);
      cycles(1);
    end

    // 4: pause ch0 for 10 cycles.
    cycles(1);
    en[0] = 1'b0;
    cycles(1);
    for (int k = 0; k < 9; k++) begin
      chk("t4_tick0_low", 32'(tick[0]), 32'h0);
      cycles(1);
    end
    en[0] = 1'b1;
    cycles(10);

    // 5: write ch3 exactly on its wrap edge, then last-write-wins, then invalid channel.
    for (int k = 0; k < 10 && m_left[3] != 0; k++) cycles(1);
    write(3, 2);
    cycles(12);
    write(3, 5);
    write(3, 7);
    write(4, 1);
    cycles(40);

    // 6: reset mid-period with a pending write.
    write(1, 4);
    chk("t6_pend1", 32'(pend[1]), 32'h1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("t6_clk", 32'(clk_out), 32'h0);
    chk("t6_tick", 32'(tick), 32'h0);
    chk("t6_pend", 32'(pend), 32'h0);
    cycles(20);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 299) == 0);
      div_wr = ($urandom_range(0, 5) == 0);
      div_ch = CHW'($urandom_range(0, 5));
      div_val = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) en = en ^ (NCH'(1) << $urandom_range(0, NCH - 1));
      cycles(1);
    end
    div_wr = 1'b0;
    rst = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
